// File: rtl/sm_pkg.sv
// Shared types and constants for the sequential sign-magnitude add/subtract unit.
// Contents: FSM state type, word layout constants, result normalization helper.
package sm_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned SIGN_BIT = 15;
  localparam int unsigned MAG_W    = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    DONE = 2'd3
  } sm_state_t;

  // A zero magnitude without overflow is always reported as +0.
  function automatic logic [WORD_W-1:0] sm_norm(input logic           sign,
                                                input logic [MAG_W-1:0] mag,
                                                input logic           ovf);
    if (!ovf && (mag == '0)) begin
      return '0;
    end
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ppa_16bit.sv
// 16-bit Kogge-Stone parallel-prefix adder with carry-in.
// Ports: a_i, b_i (16-bit operands), cin_i (carry in), sum_o (16-bit sum), cout_o (carry out).
module ppa_16bit (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] g_n;
  logic [15:0] p_n;

  // Four prefix levels; carry-in is folded into bit 0's generate so g[i] is the carry out of bit i.
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    g[0] = g[0] | (p[0] & cin_i);
    g_n  = g;
    p_n  = p;
    for (int l = 0; l < 4; l++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < 16; i++) begin
        if (i >= (1 << l)) begin
          g_n[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p_n[i] = p[i] & p[i - (1 << l)];
        end
      end
      g = g_n;
      p = p_n;
    end
    sum_o  = (a_i ^ b_i) ^ {g[14:0], cin_i};
    cout_o = g[15];
  end

endmodule

// File: rtl/sm_addsub_seq.sv
// Sequential 16-bit sign-magnitude add/subtract; one shared prefix adder run for one or two passes.
// Ports: clk, reset (async, active-high); in_valid/in_ready + a, b, sub (operand side);
//        out_valid/out_ready + result, overflow (result side); busy (not idle).
module sm_addsub_seq
  import sm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        overflow,
  output logic        busy
);

  sm_state_t         state_q, state_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [WORD_W-1:0] ma_q, ma_d;
  logic [WORD_W-1:0] mb_q, mb_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic              overflow_q, overflow_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              busy_q;

  logic [WORD_W-1:0] add_x;
  logic [WORD_W-1:0] add_y;
  logic              add_cin;
  logic [WORD_W-1:0] add_sum;
  logic              add_cout;
  logic              same_sign;

  assign same_sign = (sa_q == sb_q);

  // Adder operand mux: mA+mB, mA-mB (P1, signs differ), or mB-mA (P2).
  always_comb begin
    add_x   = ma_q;
    add_y   = mb_q;
    add_cin = 1'b0;
    if (state_q == P2) begin
      add_x   = mb_q;
      add_y   = ~ma_q;
      add_cin = 1'b1;
    end else if (!same_sign) begin
      add_y   = ~mb_q;
      add_cin = 1'b1;
    end
  end

  ppa_16bit u_adder (
    .a_i    (add_x),
    .b_i    (add_y),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    ma_d       = ma_q;
    mb_d       = mb_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a[SIGN_BIT];
          sb_d    = b[SIGN_BIT] ^ sub;
          ma_d    = {1'b0, a[MAG_W-1:0]};
          mb_d    = {1'b0, b[MAG_W-1:0]};
          state_d = P1;
        end
      end
      P1: begin
        if (same_sign) begin
          result_d   = sm_norm(sa_q, add_sum[MAG_W-1:0], add_sum[SIGN_BIT]);
          overflow_d = add_sum[SIGN_BIT];
          state_d    = DONE;
        end else if (add_cout) begin
          // |A| >= |B|: difference is already non-negative.
          result_d   = sm_norm(sa_q, add_sum[MAG_W-1:0], 1'b0);
          overflow_d = 1'b0;
          state_d    = DONE;
        end else begin
          state_d = P2;
        end
      end
      P2: begin
        result_d   = sm_norm(sb_q, add_sum[MAG_W-1:0], 1'b0);
        overflow_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and registered-output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ma_q        <= '0;
      mb_q        <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ma_q        <= ma_d;
      mb_q        <= mb_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Self-checking bench for sm_addsub_seq: directed operations with a scoreboard queue of expected results.
module tb_sm_addsub_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        overflow;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  sm_addsub_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present one operand set in an idle cycle; the accept edge follows, expected result is queued.
  task automatic send(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                      input logic [15:0] er, input logic eo, input int el);
    exp_t e;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a        = av;
    b        = bv;
    sub      = sv;
    in_valid = 1'b1;
    e.res    = er;
    e.ovf    = eo;
    e.lat    = el;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid (bounded), compare against the scoreboard, optionally stall the sink.
  task automatic receive(input string tag, input int stall, input bit wiggle);
    exp_t e;
    int   lat;
    lat = 1;
    out_ready = 1'b0;
    while ((out_valid !== 1'b1) && (lat < 8)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
    end else begin
      e.res = 16'hxxxx;
      e.ovf = 1'bx;
      e.lat = -1;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
    chk({tag, "_result"}, 32'(result), 32'(e.res));
    chk({tag, "_overflow"}, 32'(overflow), 32'(e.ovf));
    for (int i = 0; i < stall; i++) begin
      if (wiggle) begin
        in_valid = ~in_valid;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sub      = 1'($urandom);
      end
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, 32'(result), 32'(e.res));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    // in_valid stays high through the out_ready cycle when wiggling: it must not be accepted.
    if (wiggle) in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic op(input string tag, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                    input logic [15:0] er, input logic eo, input int el);
    send(tag, av, bv, sv, er, eo, el);
    receive(tag, 0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    op("add_pos",    16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 2);
    op("sub_rev",    16'h0003, 16'h0005, 1'b1, 16'h8002, 1'b0, 3);
    op("add_ovf",    16'hC000, 16'hC000, 1'b0, 16'h8000, 1'b1, 2);
    op("cancel",     16'h8005, 16'h0005, 1'b0, 16'h0000, 1'b0, 2);
    op("ovf_pos",    16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 2);
    op("negzero",    16'h8000, 16'h0000, 1'b1, 16'h0000, 1'b0, 2);
    op("zero_sub",   16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 2);
    op("neg_sub",    16'h8007, 16'h8003, 1'b1, 16'h8004, 1'b0, 2);
    op("mixed_rev",  16'h8002, 16'h0009, 1'b0, 16'h0007, 1'b0, 3);
    op("max_diff",   16'h7FFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 2);

    // Sink backpressure with input noise while the result is held.
    send("bp", 16'h0010, 16'h8004, 1'b0, 16'h000C, 1'b0, 2);
    receive("bp", 4, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("bp_no_phantom", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset while the second pass is in flight.
    send("rst_mid", 16'h0001, 16'h0002, 1'b1, 16'h8001, 1'b0, 3);
    @(posedge clk);
    #1;
    chk("rst_mid_busy_p2", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    op("post_rst", 16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
